// File: rtl/bcd_seg_scan.sv
// Multiplexed BCD-to-7-segment scanner: shadows the digit bus on load, then
// drives one digit per refresh slot with guard blanking and leading-zero suppression.
module bcd_seg_scan #(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] bcd,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   dp_in,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              err
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   dps_q, dps_d;
  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              err_q, err_d;

  logic [3:0]        cur_dig;
  logic              cur_dp;
  logic              cur_upper_zero;
  logic              zero_run;
  logic              any_invalid;
  logic              blank;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h40;
    endcase
  endfunction

  always_comb begin
    shadow_d = load ? bcd : shadow_q;
    dps_d    = load ? dp_in : dps_q;

    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DW'(REFRESH_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end

    // Walk from the MSD down so zero_run at digit k means digits k..NDIG-1 are all zero
    cur_dig        = 4'd0;
    cur_dp         = 1'b0;
    cur_upper_zero = 1'b0;
    zero_run       = 1'b1;
    any_invalid    = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_run = zero_run & (shadow_q[4*k +: 4] == 4'd0);
      if (shadow_q[4*k +: 4] > 4'd9) any_invalid = 1'b1;
      if (idx_q == IW'(k)) begin
        cur_dig        = shadow_q[4*k +: 4];
        cur_dp         = dps_q[k];
        cur_upper_zero = zero_run;
      end
    end

    blank = blank_lz && (idx_q != '0) && cur_upper_zero;

    seg_d = 7'h00;
    dp_d  = 1'b0;
    an_d  = '0;
    if (div_q >= DW'(2)) begin
      an_d = NDIG'(1) << idx_q;
      if (!blank) begin
        seg_d = seg_enc(cur_dig);
        dp_d  = cur_dp;
      end
    end

    err_d = err_q | any_invalid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= '0;
      dps_q    <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      an_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      dps_q    <= dps_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      err_q    <= err_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: directed display scenarios plus random traffic,
// all checked against a cycle-count reference model of the scan schedule.
module tb_bcd_seg_scan;

  localparam int N = 4;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] bcd;
  logic           load;
  logic           blank_lz;
  logic [N-1:0]   dp_in;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release, shadow digits, sticky error
  int         t;
  logic [3:0] m_dig [N];
  logic [N-1:0] m_dp;
  logic       m_err;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  bcd_seg_scan #(.NDIG(N), .REFRESH_DIV(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd      (bcd),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_in    (dp_in),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge: predict outputs from the pre-edge model, check, then advance the model.
  task automatic step();
    logic [6:0]   es;
    logic [N-1:0] ea;
    logic         ed;
    logic         ee;
    int           d;
    int           k;
    bit           blank;
    es = 7'h00;
    ea = '0;
    ed = 1'b0;
    ee = 1'b0;
    if (rst) begin
      d = t % R;
      k = (t / R) % N;
      if (d >= 2) begin
        ea[k] = 1'b1;
        blank = blank_lz && (k > 0);
        for (int j = k; j < N; j++)
          if (m_dig[j] != 4'd0) blank = 1'b0;
        if (!blank) begin
          es = seg_tab[m_dig[k]];
          ed = m_dp[k];
        end
      end
      ee = m_err;
      for (int j = 0; j < N; j++)
        if (m_dig[j] > 4'd9) ee = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("model seg", 16'(seg), 16'(es));
    chk("model an",  16'(an),  16'(ea));
    chk("model dp",  16'(dp),  16'(ed));
    chk("model err", 16'(err), 16'(ee));
    if (!rst) begin
      t = 0;
      for (int j = 0; j < N; j++) m_dig[j] = 4'd0;
      m_dp  = '0;
      m_err = 1'b0;
    end else begin
      m_err = ee;
      if (load) begin
        for (int j = 0; j < N; j++) m_dig[j] = bcd[4*j +: 4];
        m_dp = dp_in;
      end
      t++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    load = 1'b0;
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    load     = 1'b0;
    blank_lz = 1'b0;
    bcd      = '0;
    dp_in    = '0;
    t        = 0;
    m_dp     = '0;
    m_err    = 1'b0;
    for (int j = 0; j < N; j++) m_dig[j] = 4'd0;

    // Reset state, then an all-zero display shows 3F on digit 0
    do_reset();
    chk("reset an", 16'(an), 16'h0);
    chk("reset seg", 16'(seg), 16'h0);
    chk("reset err", 16'(err), 16'h0);
    run(3);
    chk("zero d0 an", 16'(an), 16'h1);
    chk("zero d0 seg", 16'(seg), 16'h3F);

    // 1234 scan order with guard cycles
    do_reset();
    bcd = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    run(2);
    chk("1234 d0 an", 16'(an), 16'h1);
    chk("1234 d0 seg", 16'(seg), 16'h66);
    run(2);
    chk("1234 guard an", 16'(an), 16'h0);
    run(2);
    chk("1234 d1 an", 16'(an), 16'h2);
    chk("1234 d1 seg", 16'(seg), 16'h4F);
    run(4);
    chk("1234 d2 an", 16'(an), 16'h4);
    chk("1234 d2 seg", 16'(seg), 16'h5B);
    run(4);
    chk("1234 d3 an", 16'(an), 16'h8);
    chk("1234 d3 seg", 16'(seg), 16'h06);
    run(4);
    chk("1234 wrap an", 16'(an), 16'h1);
    chk("1234 wrap seg", 16'(seg), 16'h66);

    // 0007 with leading-zero blanking, then live release of blanking
    do_reset();
    blank_lz = 1'b1;
    bcd = 16'h0007; dp_in = 4'b0101; load = 1'b1;
    step();
    load = 1'b0;
    run(2);
    chk("lz d0 seg", 16'(seg), 16'h07);
    chk("lz d0 dp", 16'(dp), 16'h1);
    run(4);
    chk("lz d1 an", 16'(an), 16'h2);
    chk("lz d1 seg", 16'(seg), 16'h00);
    run(4);
    chk("lz d2 an", 16'(an), 16'h4);
    chk("lz d2 seg", 16'(seg), 16'h00);
    chk("lz d2 dp", 16'(dp), 16'h0);
    run(4);
    chk("lz d3 an", 16'(an), 16'h8);
    chk("lz d3 seg", 16'(seg), 16'h00);
    blank_lz = 1'b0;
    step();
    chk("lz off d3 an", 16'(an), 16'h8);
    chk("lz off d3 seg", 16'(seg), 16'h3F);

    // Invalid code: dash, sticky error
    do_reset();
    bcd = 16'h00C5; dp_in = 4'b0000; load = 1'b1;
    step();
    chk("err pre", 16'(err), 16'h0);
    load = 1'b0;
    step();
    chk("err set", 16'(err), 16'h1);
    step();
    chk("C5 d0 seg", 16'(seg), 16'h6D);
    run(4);
    chk("C5 d1 an", 16'(an), 16'h2);
    chk("C5 d1 seg", 16'(seg), 16'h40);
    run(4);
    chk("C5 d2 an", 16'(an), 16'h4);
    chk("C5 d2 seg", 16'(seg), 16'h3F);
    bcd = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    run(5);
    chk("err sticky", 16'(err), 16'h1);

    // Reset at divider 2 of slot 2
    do_reset();
    bcd = 16'h00C5; load = 1'b1;
    step();
    load = 1'b0;
    run(9);
    chk("midslot err before", 16'(err), 16'h1);
    rst = 1'b0;
    step();
    chk("midslot an", 16'(an), 16'h0);
    chk("midslot seg", 16'(seg), 16'h00);
    chk("midslot err", 16'(err), 16'h0);
    rst = 1'b1;
    step();
    chk("restart guard an", 16'(an), 16'h0);
    run(2);
    chk("restart d0 an", 16'(an), 16'h1);
    chk("restart d0 seg", 16'(seg), 16'h3F);

    // Load coinciding with the divider wrap
    do_reset();
    bcd = 16'h0000;
    run(3);
    bcd = 16'h9999; load = 1'b1;
    step();
    chk("wrapload old d0", 16'(seg), 16'h3F);
    load = 1'b0;
    step();
    chk("wrapload g0 an", 16'(an), 16'h0);
    step();
    chk("wrapload g1 an", 16'(an), 16'h0);
    step();
    chk("wrapload d1 an", 16'(an), 16'h2);
    chk("wrapload d1 seg", 16'(seg), 16'h6F);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) != 0);
      load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      dp_in = N'($urandom);
      for (int j = 0; j < N; j++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      bcd[4*j +: 4] = 4'd0;
        else if (r < 9) bcd[4*j +: 4] = 4'($urandom_range(0, 9));
        else            bcd[4*j +: 4] = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
